// File: rtl/alu_dispatch.sv
// Initiator side of the ALU handshake: issues one command, waits for completion, returns the result.
// Latency: 3 edges per ALU op (1 for a trapped divide-by-zero); one op in flight, DONE holds until out_ready.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef STATE_SIZE0
`define STATE_SIZE0 2
`endif
`ifndef ALU_BEGIN
`define ALU_BEGIN 1
`endif
`ifndef CMD_ADD
`define CMD_ADD 4'd1
`endif
`ifndef CMD_MUL
`define CMD_MUL 4'd3
`endif
`ifndef CMD_DIV
`define CMD_DIV 4'd4
`endif

module alu_dispatch #(
  parameter int unsigned             DATA_W     = `DATA_SIZE,
  parameter int unsigned             STATE_W    = `STATE_SIZE0 + 1,
  parameter logic [STATE_W-1:0]      BEGIN_CODE = `ALU_BEGIN,
  parameter logic [STATE_W-1:0]      IDLE_CODE  = '0,
  parameter int unsigned             TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_cmd,
  input  logic [DATA_W-1:0]  in_src0,
  input  logic [DATA_W-1:0]  in_src1,
  output logic [31:0]        alu_command,
  output logic [STATE_W-1:0] alu_state,
  output logic [DATA_W-1:0]  alu_src0,
  output logic [DATA_W-1:0]  alu_src1,
  input  logic               alu_next_state,
  input  logic [DATA_W-1:0]  alu_dst,
  input  logic [DATA_W-1:0]  alu_dst_h,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_res,
  output logic [DATA_W-1:0]  out_res_h,
  output logic [1:0]         out_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_res_q, out_res_d;
  logic [DATA_W-1:0]   out_res_h_q, out_res_h_d;
  logic [1:0]          out_err_q, out_err_d;
  logic [STATE_W-1:0]  alu_state_q, alu_state_d;
  logic [31:0]         alu_command_q, alu_command_d;
  logic [DATA_W-1:0]   alu_src0_q, alu_src0_d;
  logic [DATA_W-1:0]   alu_src1_q, alu_src1_d;
  logic [7:0]          timer_q, timer_d;

  logic is_div0;
  logic alu_done;

  assign is_div0 = (in_cmd[31:28] == `CMD_DIV) && (in_src1 == '0);
  // A floating or unknown completion line must never be taken as a pulse.
  assign alu_done = (alu_next_state === 1'b1);

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_res_d     = out_res_q;
    out_res_h_d   = out_res_h_q;
    out_err_d     = out_err_q;
    alu_state_d   = alu_state_q;
    alu_command_d = alu_command_q;
    alu_src0_d    = alu_src0_q;
    alu_src1_d    = alu_src1_q;
    timer_d       = timer_q;

    case (state_q)
      S_IDLE: begin
        alu_state_d = IDLE_CODE;
        if (in_valid) begin
          alu_command_d = in_cmd;
          alu_src0_d    = in_src0;
          alu_src1_d    = in_src1;
          in_ready_d    = 1'b0;
          if (is_div0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            out_res_d   = '0;
            out_res_h_d = '0;
            out_err_d   = ERR_DIV0;
          end else begin
            state_d     = S_ISSUE;
            alu_state_d = BEGIN_CODE;
          end
        end
      end

      S_ISSUE: begin
        alu_state_d = IDLE_CODE;
        timer_d     = '0;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (alu_done) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_res_d   = alu_dst;
          out_res_h_d = alu_dst_h;
          out_err_d   = ERR_OK;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_res_d   = '0;
          out_res_h_d = '0;
          out_err_d   = ERR_TMO;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        alu_state_d = IDLE_CODE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_res_q     <= '0;
      out_res_h_q   <= '0;
      out_err_q     <= ERR_OK;
      alu_state_q   <= IDLE_CODE;
      alu_command_q <= '0;
      alu_src0_q    <= '0;
      alu_src1_q    <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_res_q     <= out_res_d;
      out_res_h_q   <= out_res_h_d;
      out_err_q     <= out_err_d;
      alu_state_q   <= alu_state_d;
      alu_command_q <= alu_command_d;
      alu_src0_q    <= alu_src0_d;
      alu_src1_q    <= alu_src1_d;
      timer_q       <= timer_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_res     = out_res_q;
  assign out_res_h   = out_res_h_q;
  assign out_err     = out_err_q;
  assign alu_state   = alu_state_q;
  assign alu_command = alu_command_q;
  assign alu_src0    = alu_src0_q;
  assign alu_src1    = alu_src1_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: table of single operations plus reset, last-cycle, backpressure and back-to-back sequences.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef STATE_SIZE0
`define STATE_SIZE0 2
`endif
`ifndef ALU_BEGIN
`define ALU_BEGIN 1
`endif
`ifndef CMD_ADD
`define CMD_ADD 4'd1
`endif
`ifndef CMD_MUL
`define CMD_MUL 4'd3
`endif
`ifndef CMD_DIV
`define CMD_DIV 4'd4
`endif

module tb_alu_dispatch;
  localparam int SW = `STATE_SIZE0 + 1;
  localparam logic [SW-1:0] BEG  = `ALU_BEGIN;
  localparam logic [SW-1:0] IDLC = '0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_cmd, in_src0, in_src1;
  logic [31:0] alu_command, alu_src0, alu_src1;
  logic [SW-1:0] alu_state;
  wire         alu_next_state;
  logic [31:0] alu_dst, alu_dst_h;
  logic        out_valid, out_ready;
  logic [31:0] out_res, out_res_h;
  logic [1:0]  out_err;

  int total = 0;
  int bad   = 0;

  logic        auto_en    = 1'b1;
  logic        auto_pulse = 1'b0;
  logic        man_pulse  = 1'b0;
  logic [31:0] auto_dst   = '0;
  logic [31:0] auto_dst_h = '0;
  logic [31:0] man_dst    = '0;
  logic [31:0] man_dst_h  = '0;

  alu_dispatch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_src0(in_src0), .in_src1(in_src1),
    .alu_command(alu_command), .alu_state(alu_state),
    .alu_src0(alu_src0), .alu_src1(alu_src1),
    .alu_next_state(alu_next_state), .alu_dst(alu_dst), .alu_dst_h(alu_dst_h),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_res_h(out_res_h), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Reference ALU: answers one cycle after it sees BEGIN; silent lines float.
  function automatic logic [63:0] alu_model(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    case (c[31:28])
      `CMD_ADD: r = {32'h0, a} + {32'h0, b};
      `CMD_MUL: r = {32'h0, a} * {32'h0, b};
      `CMD_DIV: r = (b == 0) ? 64'h0 : {a % b, a / b};
      default:  r = {32'h0, a};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (auto_en && alu_state == BEG) begin
      auto_pulse <= 1'b1;
      {auto_dst_h, auto_dst} <= alu_model(alu_command, alu_src0, alu_src1);
    end else begin
      auto_pulse <= 1'b0;
    end
  end

  assign alu_next_state = (auto_pulse || man_pulse) ? 1'b1 : 1'bz;
  assign alu_dst   = man_pulse ? man_dst   : auto_dst;
  assign alu_dst_h = man_pulse ? man_dst_h : auto_dst_h;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
    end
  endtask

  // Runs one op with out_ready high; starts and ends at a negedge with the DUT idle.
  task automatic run_op(input logic [31:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [31:0] rh, output logic [1:0] e,
                        output int lat, output int nb, output logic [31:0] cmd_seen, output bit got);
    in_cmd = c; in_src0 = a; in_src1 = b; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    cmd_seen = alu_command;
    lat = 0; nb = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (alu_state == BEG) nb++;
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    r = out_res; rh = out_res_h; e = out_err;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_valid(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  typedef struct {
    logic [31:0] cmd, s0, s1;
    bit          silent;
    logic [31:0] res, res_h;
    logic [1:0]  err;
    int          lat, nb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [31:0] r, rh, cs;
    logic [1:0]  e;
    int          lat, nb, cnt, k, nres;
    bit          got, acc;
    int          vcyc[3];
    logic [63:0] gres[3];
    logic [31:0] ma[3], mb[3];
    logic [63:0] mexp[3];

    vecs[0] = '{{`CMD_ADD, 28'h0}, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd1, 32'd1, 2'b00, 2, 1};
    vecs[1] = '{{`CMD_ADD, 28'h0}, 32'd5, 32'd7, 1'b0, 32'd12, 32'd0, 2'b00, 2, 1};
    vecs[2] = '{{`CMD_DIV, 28'h0}, 32'd7, 32'd0, 1'b0, 32'd0, 32'd0, 2'b01, 0, 0};
    vecs[3] = '{{`CMD_DIV, 28'h0}, 32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 2'b00, 2, 1};
    vecs[4] = '{{`CMD_MUL, 28'h0}, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'd0, 32'd1, 2'b00, 2, 1};
    vecs[5] = '{{`CMD_MUL, 28'h0}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'hFFFF_FFFE, 2'b00, 2, 1};
    vecs[6] = '{{`CMD_ADD, 28'h0}, 32'd1, 32'd1, 1'b1, 32'd0, 32'd0, 2'b10, 16, 1};
    vecs[7] = '{{`CMD_DIV, 28'hABC_DEF0}, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 2'b01, 0, 0};
    vecs[8] = '{{4'hF, 28'h0}, 32'h0000_1234, 32'd0, 1'b0, 32'h0000_1234, 32'd0, 2'b00, 2, 1};
    vecs[9] = '{{`CMD_DIV, 28'h0}, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 2'b00, 2, 1};

    rst = 1'b1; in_valid = 1'b0; in_cmd = '0; in_src0 = '0; in_src1 = '0; out_ready = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_alu_state", 64'(alu_state), 64'(IDLC));
    chk("rst_alu_command", 64'(alu_command), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_out_res", 64'(out_res), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      auto_en = !vecs[i].silent;
      run_op(vecs[i].cmd, vecs[i].s0, vecs[i].s1, r, rh, e, lat, nb, cs, got);
      chk($sformatf("v%0d_got", i), 64'(got), 64'd1);
      chk($sformatf("v%0d_res", i), 64'(r), 64'(vecs[i].res));
      chk($sformatf("v%0d_res_h", i), 64'(rh), 64'(vecs[i].res_h));
      chk($sformatf("v%0d_err", i), 64'(e), 64'(vecs[i].err));
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_begins", i), 64'(nb), 64'(vecs[i].nb));
      chk($sformatf("v%0d_cmd", i), 64'(cs), 64'(vecs[i].cmd));
      chk($sformatf("v%0d_post_valid", i), 64'(out_valid), 64'd0);
      chk($sformatf("v%0d_post_ready", i), 64'(in_ready), 64'd1);
    end
    auto_en = 1'b1;

    // Reset while waiting on a silent ALU, then a stray completion pulse.
    auto_en = 1'b0;
    in_cmd = {`CMD_ADD, 28'h0}; in_src0 = 32'd9; in_src1 = 32'd9; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_alu_state", 64'(alu_state), 64'(IDLC));
    chk("midrst_out_err", 64'(out_err), 64'd0);
    chk("midrst_alu_src0", 64'(alu_src0), 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); man_dst = 32'h1111; man_dst_h = 32'h2222; man_pulse = 1'b1;
    @(negedge clk); man_pulse = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("late_pulse_valid_cnt", 64'(cnt), 64'd0);
    chk("late_pulse_in_ready", 64'(in_ready), 64'd1);

    // Completion on the final WAIT cycle beats the timeout.
    in_cmd = {`CMD_ADD, 28'h0}; in_src0 = 32'd1; in_src1 = 32'd2; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("last_no_early_timeout", 64'(out_valid), 64'd0);
    man_dst = 32'hAAAA; man_dst_h = 32'h5555; man_pulse = 1'b1;
    @(posedge clk); @(negedge clk); man_pulse = 1'b0;
    chk("last_valid", 64'(out_valid), 64'd1);
    chk("last_err", 64'(out_err), 64'd0);
    chk("last_res", 64'(out_res), 64'hAAAA);
    chk("last_res_h", 64'(out_res_h), 64'h5555);
    @(posedge clk); @(negedge clk);
    auto_en = 1'b1;

    // Backpressure in DONE.
    out_ready = 1'b0;
    in_cmd = {`CMD_ADD, 28'h0}; in_src0 = 32'd3; in_src1 = 32'd4; in_valid = 1'b1;
    @(posedge clk); @(negedge clk); in_valid = 1'b0;
    wait_valid("bp_first_valid");
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_cmd = {`CMD_ADD, 28'h0}; in_src0 = 32'd10; in_src1 = 32'd20;
      chk($sformatf("bp%0d_res", c), 64'(out_res), 64'd7);
      chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("bp%0d_src0", c), 64'(alu_src0), 64'd3);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp_rel_valid", 64'(out_valid), 64'd0);
    chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
    chk("bp_rel_not_taken", 64'(alu_src0), 64'd3);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_in_ready", 64'(in_ready), 64'd0);
    chk("bp_next_src0", 64'(alu_src0), 64'd10);
    wait_valid("bp_second_valid");
    chk("bp_second_res", 64'(out_res), 64'd30);
    @(posedge clk); @(negedge clk);

    // Back-to-back MULs with in_valid and out_ready held high.
    ma[0] = 32'h0001_0000; mb[0] = 32'h0001_0000; mexp[0] = 64'h0000_0001_0000_0000;
    ma[1] = 32'd3;         mb[1] = 32'd5;         mexp[1] = 64'd15;
    ma[2] = 32'hFFFF_FFFF; mb[2] = 32'd2;         mexp[2] = 64'h0000_0001_FFFF_FFFE;
    k = 0; nres = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && nres < 3) begin
        gres[nres] = {out_res_h, out_res};
        vcyc[nres] = c;
        nres++;
      end
      if (k < 3) begin
        in_valid = 1'b1; in_cmd = {`CMD_MUL, 28'h0}; in_src0 = ma[k]; in_src1 = mb[k];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepted", 64'(k), 64'd3);
    chk("b2b_results", 64'(nres), 64'd3);
    if (nres == 3) begin
      for (int j = 0; j < 3; j++) chk($sformatf("b2b_res%0d", j), gres[j], mexp[j]);
      chk("b2b_gap01", 64'(vcyc[1] - vcyc[0]), 64'd4);
      chk("b2b_gap12", 64'(vcyc[2] - vcyc[1]), 64'd4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Initiator side of the ALU handshake.
- Accepts one command plus two operands over a valid/ready input channel, and drives the ALU's command, src0, src1 and state inputs, pulsing state to the ALU begin code for one cycle.
- Waits for the ALU's next_state completion pulse, captures dst/dst_h, and presents the result on a valid/ready output channel.
- Traps divide-by-zero locally and times out a silent ALU.

Parameters:
- DATA_W, 32, operand/result width; equals `DATA_SIZE.
- STATE_W, `STATE_SIZE0+1, width of the ALU state bus.
- BEGIN_CODE, `ALU_BEGIN, state value that starts an ALU operation.
- IDLE_CODE, 0, state value driven whenever no operation starts; must differ from BEGIN_CODE.
- TIMEOUT, 15, WAIT cycles before declaring the ALU dead; range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  command/operands valid.
- in_ready  out  1  dispatcher can accept.
- in_cmd  in  32  command word; cmd_code = in_cmd[31:28].
- in_src0  in  DATA_W  first operand.
- in_src1  in  DATA_W  second operand.
- alu_command  out  32  to ALU command.
- alu_state  out  STATE_W  to ALU state.
- alu_src0  out  DATA_W  to ALU src0.
- alu_src1  out  DATA_W  to ALU src1.
- alu_next_state  in  1  ALU completion pulse; may float (z).
- alu_dst  in  DATA_W  ALU low result.
- alu_dst_h  in  DATA_W  ALU high result / remainder.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_res  out  DATA_W  low result.
- out_res_h  out  DATA_W  high result.
- out_err  out  2  00 ok, 01 divide-by-zero, 10 timeout.

Behaviour:
- Reset (rst=0, async, any state):
  - FSM goes to IDLE.
  - in_ready=1; out_valid=0.
  - out_res, out_res_h, out_err = 0.
  - alu_state=IDLE_CODE; alu_command, alu_src0, alu_src1 = 0.
  - Timer=0.
  - An operation in flight is abandoned; a late alu_next_state after reset release is ignored because the FSM is in IDLE.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge, latch in_cmd/in_src0/in_src1 onto alu_command/alu_src0/alu_src1.
  - If cmd_code==`CMD_DIV and in_src1==0, go to DONE with out_res=0, out_res_h=0, out_err=01, and never pulse the ALU.
  - Otherwise go to ISSUE.
- ISSUE:
  - in_ready=0; alu_state=BEGIN_CODE for exactly one cycle.
  - Clear the timer; go to WAIT.
- WAIT:
  - alu_state=IDLE_CODE; alu_command/alu_src0/alu_src1 held stable.
  - Completion counts only when alu_next_state is exactly 1; z or x is not completion.
  - On completion, capture alu_dst into out_res and alu_dst_h into out_res_h, set out_err=00, and go to DONE.
  - Otherwise increment the timer. When timer==TIMEOUT-1 and no completion, go to DONE with out_res=0, out_res_h=0, out_err=10.
  - Completion and timeout on the same edge: completion wins.
- DONE:
  - out_valid=1; out_res, out_res_h and out_err held stable while out_ready=0.
  - On out_ready, clear out_valid and go to IDLE. in_ready rises the following cycle; there is no same-cycle bypass.
- Latency, ALU op: accept edge E0 → alu_state=BEGIN during cycle E0..E1 → ALU pulses next_state after E1 → capture at E2 → out_valid high after E2.
- Latency, div0 trap: out_valid high after E0.
- Throughput: at most one operation in flight; minimum 4 cycles per ALU op with out_ready held high.
- Widths: out_res and out_res_h are passed through unmodified; no arithmetic is performed in this block.

Test Plan:
- Reset: apply rst=0 mid-WAIT → immediately in_ready=1, out_valid=0, alu_state=IDLE_CODE, out_err=0. A later next_state pulse → no out_valid.
- ADD: in_cmd=`CMD_ADD<<28, src0=0xFFFFFFFF, src1=2, ALU model pulses next_state → out_res=1, out_res_h=1, out_err=00, out_valid 2 cycles after accept, BEGIN visible for exactly 1 cycle.
- DIV by zero: `CMD_DIV, src0=7, src1=0 → alu_state never BEGIN, out_valid the cycle after accept, out_err=01, out_res=out_res_h=0. DIV with src1=2 → out_res=3, out_res_h=1.
- Timeout: ALU model silent (next_state=z) → out_valid after TIMEOUT WAIT cycles (15 at default), out_err=10. Pulse at the last WAIT cycle → out_err=00.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_res stable, in_ready=0, a new in_valid is not accepted. Release → IDLE, and the next command is accepted one cycle later.
- Back-to-back: 3 MUL commands with in_valid and out_ready held high → 3 results in order, each 4 cycles apart, with correct 64-bit {out_res_h, out_res} (e.g. 0x10000*0x10000 → h=1, l=0).
